// File: rtl/nbus_wait_sram.sv
// Native-bus SRAM slave: captures one access, waits WAIT_CYCLES, then pulses ready for one cycle.
// The array is preloaded with INIT_VALUE and is never touched by reset.
module nbus_wait_sram #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 8,
  parameter int                DEPTH       = 200,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [DATA_W-1:0] INIT_VALUE  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              err
);

  // Handshake: the master raises cs with we and/or re and holds it until it sees ready;
  // ready is high for exactly one cycle per captured access, and err is only meaningful with it.
  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W + 1)'(DEPTH);

  state_t            state, next_state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] data_l;
  logic              we_l, re_l;

  logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: INIT_VALUE};

  logic              cap;
  logic              do_access;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_we, a_re;
  logic              in_range, conflict;

  assign cap = cs && (we || re);

  // With zero wait states the access completes on the capture edge, so use the live inputs then.
  assign a_addr   = (state == IDLE) ? addr    : addr_l;
  assign a_data   = (state == IDLE) ? data_in : data_l;
  assign a_we     = (state == IDLE) ? we      : we_l;
  assign a_re     = (state == IDLE) ? re      : re_l;
  assign in_range = {1'b0, a_addr} < DEPTH_W;
  assign conflict = a_we && a_re;

  assign do_access = (next_state == ACK) && !reset;
  assign ready     = (state == ACK);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (cap) next_state = (WAIT_CYCLES == 0) ? ACK : WAIT;
      WAIT: begin
        if (!cs)            next_state = IDLE;
        else if (cnt == '0) next_state = ACK;
      end
      ACK:  next_state = HOLD;
      HOLD: if (!cs) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_l   <= '0;
      data_l   <= '0;
      we_l     <= 1'b0;
      re_l     <= 1'b0;
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && cap) begin
        addr_l <= addr;
        data_l <= data_in;
        we_l   <= we;
        re_l   <= re;
        cnt    <= WAIT_INIT;
      end else if (state == WAIT && cs) begin
        cnt <= cnt - 4'd1;
      end
      err <= do_access ? (conflict || !in_range) : 1'b0;
      // A conflicting we&re leaves data_out alone; an out-of-range read returns zero.
      if (do_access && a_re && !conflict)
        data_out <= in_range ? mem[a_addr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_access && a_we && !conflict && in_range)
      mem[a_addr] <= a_data;
  end

endmodule

// File: tb/tb_nbus_wait_sram.sv
// Bench for nbus_wait_sram: directed scenarios followed by random accesses, checked by a
// monitor that pops expected {err, data_out} pairs from a queue on every ready pulse.
module tb_nbus_wait_sram;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;
  localparam int WAITS  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              cs, we, re;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              ready, err;

  int checks = 0;
  int errors = 0;

  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W-1:0] model_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] model_dout;

  nbus_wait_sram #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAITS), .INIT_VALUE(8'h00)
  ) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .re(re), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: one access = one response; memory and data_out follow the access rules directly.
  task automatic model_access(input logic w, input logic r, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d);
    logic e;
    e = (w && r) || (a >= DEPTH);
    if (!(w && r)) begin
      if (w && a < DEPTH) model_mem[a] = d;
      if (r) model_dout = (a < DEPTH) ? model_mem[a] : '0;
    end
    exp_q.push_back({e, model_dout});
  endtask

  task automatic access(input logic w, input logic r, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input int hold_extra);
    int  lat;
    bit  seen;
    model_access(w, r, a, d);
    @(posedge clk); #1;
    cs = 1'b1; we = w; re = r; addr = a; data_in = d;
    @(posedge clk); #1;
    addr = ADDR_W'($urandom);
    data_in = DATA_W'($urandom);
    lat = 1;
    seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      if (ready) seen = 1;
      else lat++;
    end
    checks++;
    if (!seen || lat != WAITS + 1) begin
      errors++;
      $display("FAIL latency addr=%0h got=%0d seen=%0d required=%0d", a, lat, seen, WAITS + 1);
    end
    repeat (hold_extra) @(posedge clk);
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0; re = 1'b0;
    @(negedge clk);
    checks++;
    if (data_out !== model_dout) begin
      errors++;
      $display("FAIL data_out_hold addr=%0h got=%0h required=%0h", a, data_out, model_dout);
    end
  endtask

  task automatic abort_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    cs = 1'b1; we = 1'b1; re = 1'b0; addr = a; data_in = d;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic reset_mid_wait(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    cs = 1'b1; we = 1'b1; re = 1'b0; addr = a; data_in = d;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait ready=%b data_out=%0h required ready=0 data_out=0", ready, data_out);
    end
    model_dout = '0;
    cs = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready data_out=%0h err=%b required no pulse", data_out, err);
        end else begin
          logic [DATA_W:0] e;
          e = exp_q.pop_front();
          if ({err, data_out} !== e) begin
            errors++;
            $display("FAIL response got err=%b data=%0h required err=%b data=%0h",
                     err, data_out, e[DATA_W], e[DATA_W-1:0]);
          end
        end
      end else if (err) begin
        checks++;
        errors++;
        $display("FAIL err_without_ready got err=1 required 0");
      end
    end
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) model_mem[i] = '0;
    model_dout = '0;
    reset = 1'b1; cs = 1'b0; we = 1'b0; re = 1'b0; addr = '0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0 || err !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_state ready=%b err=%b data_out=%0h required 0 0 0", ready, err, data_out);
    end
    reset = 1'b0;

    access(1'b1, 1'b0, 8'h10, 8'hA5, 0);
    access(1'b0, 1'b1, 8'h10, 8'h00, 0);
    access(1'b1, 1'b0, 8'hF0, 8'h33, 0);
    access(1'b0, 1'b1, 8'hF0, 8'h00, 0);
    access(1'b1, 1'b0, 8'h20, 8'h5C, 0);
    abort_write(8'h20, 8'h77);
    access(1'b0, 1'b1, 8'h20, 8'h00, 0);
    access(1'b1, 1'b0, 8'h40, 8'h3E, 5);
    access(1'b0, 1'b1, 8'h40, 8'h00, 0);
    access(1'b1, 1'b0, 8'd199, 8'hC7, 0);
    access(1'b1, 1'b0, 8'd200, 8'hC8, 0);
    access(1'b0, 1'b1, 8'd199, 8'h00, 0);
    access(1'b0, 1'b1, 8'd200, 8'h00, 0);
    access(1'b1, 1'b1, 8'h10, 8'hEE, 0);
    access(1'b0, 1'b1, 8'h10, 8'h00, 0);
    access(1'b1, 1'b0, 8'h30, 8'h11, 0);
    reset_mid_wait(8'h30, 8'h99);
    access(1'b0, 1'b1, 8'h30, 8'h00, 0);

    for (int n = 0; n < 150; n++) begin
      int               kind;
      logic [ADDR_W-1:0] a;
      kind = $urandom_range(0, 19);
      a = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(DEPTH, 255))
                                      : ADDR_W'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1) a = ADDR_W'($urandom_range(0, 15));
      if (kind < 9)       access(1'b1, 1'b0, a, DATA_W'($urandom), $urandom_range(0, 3));
      else if (kind < 18) access(1'b0, 1'b1, a, DATA_W'($urandom), $urandom_range(0, 3));
      else                access(1'b1, 1'b1, a, DATA_W'($urandom), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (10) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_ready outstanding=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
